// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter with a registered one-hot grant, valid/ready handoff
// and a binary-encoded grant index. Two-state FSM: IDLE and GRANT.
module rr_arbiter_enc #(
    parameter  int width = 8,
    localparam int m     = $clog2(width)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [width-1:0] req_i,
    input  logic             ready_i,
    output logic [width-1:0] gnt_o,
    output logic [m-1:0]     idx_o,
    output logic             valid_o,
    output logic [m-1:0]     ptr_o
);

    // Handshake: a grant is transferred in any cycle where valid_o && ready_i.
    // gnt_o/idx_o are frozen while valid_o is high and ready_i is low.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] gnt_q, gnt_d;
    logic [m-1:0]     ptr_q, ptr_d;

    logic [m-1:0]     idx_w;
    logic [m-1:0]     next_ptr_w;
    logic [m-1:0]     scan_ptr_w;
    logic [width-1:0] cand_w;
    logic [width-1:0] pick_w;
    logic             handshake_w;

    function automatic logic [m-1:0] onehot_enc(input logic [width-1:0] oh);
        logic [m-1:0] enc;
        enc = '0;
        for (int i = 0; i < width; i++) begin
            if (oh[i]) begin
                enc = enc | m'(i);
            end
        end
        return enc;
    endfunction

    // Lowest set bit at or above p; if none, lowest set bit overall.
    function automatic logic [width-1:0] rr_pick(input logic [width-1:0] r,
                                                 input logic [m-1:0]     p);
        logic [width-1:0] hi;
        logic [width-1:0] src;
        logic [width-1:0] sel;
        for (int i = 0; i < width; i++) begin
            hi[i] = r[i] && (i >= int'(p));
        end
        src = (hi != '0) ? hi : r;
        sel = '0;
        for (int i = width - 1; i >= 0; i--) begin
            if (src[i]) begin
                sel = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    assign idx_w       = onehot_enc(gnt_q);
    assign next_ptr_w  = idx_w + m'(1);
    assign handshake_w = (state_q == GRANT) && ready_i;
    // The current holder's own request never takes part in the next selection.
    assign cand_w      = req_i & ~gnt_q;
    assign scan_ptr_w  = (state_q == GRANT) ? next_ptr_w : ptr_q;
    assign pick_w      = rr_pick(cand_w, scan_ptr_w);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (cand_w != '0) begin
                    gnt_d   = pick_w;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (handshake_w) begin
                    ptr_d = next_ptr_w;
                    if (cand_w != '0) begin
                        gnt_d = pick_w;
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign idx_o   = idx_w;
    assign valid_o = (state_q == GRANT);
    assign ptr_o   = ptr_q;

endmodule
